// File: rtl/bp_fe_pred_update_sched.sv
// bp_fe_pred_update_sched
//   Owns the front-end BHT and BTB write ports. After reset it walks both tables writing
//   their reset value, holding fetch off (ready_o=0) until the walk is done. In run mode it
//   arbitrates the single BHT write port between backend redirects (mispredicts, zero
//   latency) and a small FIFO of attaboys (correct resolutions), and forwards BTB updates.
// Ports
//   clk_i, reset_n_i                       clock, asynchronous active-low reset
//   redirect_*_i                           backend redirect (single-cycle, never stalled)
//   attaboy_v_i, attaboy_bht_idx_i         attaboy request; attaboy_yumi_o accepts it
//   bht_w_*_o                              BHT write port
//   btb_w_*_o                              BTB write port
//   ready_o                                tables initialised, fetch may read
module bp_fe_pred_update_sched #(
  parameter int unsigned vaddr_width_p   = 39,
  parameter int unsigned bht_idx_width_p = 9,
  parameter int unsigned btb_idx_width_p = 6,
  parameter int unsigned btb_tag_width_p = 10,
  parameter int unsigned attaboy_els_p   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       redirect_v_i,
  input  logic                       redirect_br_i,
  input  logic [bht_idx_width_p-1:0] redirect_bht_idx_i,
  input  logic                       redirect_btb_w_i,
  input  logic                       redirect_btb_clr_i,
  input  logic                       redirect_btb_jmp_i,
  input  logic [btb_idx_width_p-1:0] redirect_btb_idx_i,
  input  logic [btb_tag_width_p-1:0] redirect_btb_tag_i,
  input  logic [vaddr_width_p-1:0]   redirect_tgt_i,
  input  logic                       attaboy_v_i,
  input  logic [bht_idx_width_p-1:0] attaboy_bht_idx_i,
  output logic                       attaboy_yumi_o,
  output logic                       bht_w_v_o,
  output logic [bht_idx_width_p-1:0] bht_w_idx_o,
  output logic                       bht_w_clr_o,
  output logic                       bht_w_correct_o,
  output logic                       btb_w_v_o,
  output logic                       btb_w_clr_o,
  output logic                       btb_w_jmp_o,
  output logic [btb_idx_width_p-1:0] btb_w_idx_o,
  output logic [btb_tag_width_p-1:0] btb_w_tag_o,
  output logic [vaddr_width_p-1:0]   btb_w_tgt_o,
  output logic                       ready_o
);

  localparam int unsigned CntW = (bht_idx_width_p > btb_idx_width_p) ? bht_idx_width_p
                                                                     : btb_idx_width_p;
  localparam int unsigned PtrW       = $clog2(attaboy_els_p);
  localparam int unsigned BhtEntries = 1 << bht_idx_width_p;
  localparam int unsigned BtbEntries = 1 << btb_idx_width_p;

  typedef enum logic [1:0] {StIdle, StClear, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Pointers carry an extra MSB so full and empty are distinguishable.
  logic [PtrW:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [bht_idx_width_p-1:0] mem_q [attaboy_els_p];

  logic run, empty, full, redir_bht, enq, deq, clr_bht, clr_btb;
  logic [bht_idx_width_p-1:0] head;

  assign run       = (state_q == StRun);
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                     (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign redir_bht = redirect_v_i & redirect_br_i;
  // full is registered: a slot freed by this cycle's dequeue is not reusable until next cycle.
  assign enq       = run & attaboy_v_i & ~full;
  // A redirect owns the BHT port; the blocked head simply waits.
  assign deq       = run & ~empty & ~redir_bht;
  assign head      = mem_q[rptr_q[PtrW-1:0]];
  assign clr_bht   = (32'(cnt_q) < BhtEntries);
  assign clr_btb   = (32'(cnt_q) < BtbEntries);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    unique case (state_q)
      StIdle: begin
        state_d = StClear;
        cnt_d   = '0;
      end
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = StRun;
      end
      StRun: begin
        if (enq) wptr_d = wptr_q + 1'b1;
        if (deq) rptr_d = rptr_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Queue storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q[PtrW-1:0]] <= attaboy_bht_idx_i;
  end

  always_comb begin
    attaboy_yumi_o  = 1'b0;
    bht_w_v_o       = 1'b0;
    bht_w_idx_o     = '0;
    bht_w_clr_o     = 1'b0;
    bht_w_correct_o = 1'b0;
    btb_w_v_o       = 1'b0;
    btb_w_clr_o     = 1'b0;
    btb_w_jmp_o     = 1'b0;
    btb_w_idx_o     = '0;
    btb_w_tag_o     = '0;
    btb_w_tgt_o     = '0;
    ready_o         = 1'b0;
    unique case (state_q)
      StClear: begin
        bht_w_v_o   = clr_bht;
        bht_w_clr_o = clr_bht;
        if (clr_bht) bht_w_idx_o = cnt_q[bht_idx_width_p-1:0];
        btb_w_v_o   = clr_btb;
        btb_w_clr_o = clr_btb;
        if (clr_btb) btb_w_idx_o = cnt_q[btb_idx_width_p-1:0];
      end
      StRun: begin
        ready_o        = 1'b1;
        attaboy_yumi_o = enq;
        if (redir_bht) begin
          bht_w_v_o   = 1'b1;
          bht_w_idx_o = redirect_bht_idx_i;
        end else if (!empty) begin
          bht_w_v_o       = 1'b1;
          bht_w_idx_o     = head;
          bht_w_correct_o = 1'b1;
        end
        btb_w_v_o   = redirect_v_i & redirect_btb_w_i;
        btb_w_clr_o = redirect_btb_clr_i;
        btb_w_jmp_o = redirect_btb_jmp_i;
        btb_w_idx_o = redirect_btb_idx_i;
        btb_w_tag_o = redirect_btb_tag_i;
        btb_w_tgt_o = redirect_tgt_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bp_fe_pred_update_sched.sv
module tb_bp_fe_pred_update_sched;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        redirect_v_i, redirect_br_i, redirect_btb_w_i, redirect_btb_clr_i;
  logic        redirect_btb_jmp_i;
  logic [8:0]  redirect_bht_idx_i;
  logic [5:0]  redirect_btb_idx_i;
  logic [9:0]  redirect_btb_tag_i;
  logic [38:0] redirect_tgt_i;
  logic        attaboy_v_i;
  logic [8:0]  attaboy_bht_idx_i;
  logic        attaboy_yumi_o, bht_w_v_o, bht_w_clr_o, bht_w_correct_o;
  logic [8:0]  bht_w_idx_o;
  logic        btb_w_v_o, btb_w_clr_o, btb_w_jmp_o, ready_o;
  logic [5:0]  btb_w_idx_o;
  logic [9:0]  btb_w_tag_o;
  logic [38:0] btb_w_tgt_o;

  int compared   = 0;
  int mismatched = 0;

  bp_fe_pred_update_sched dut (
    .clk_i              (clk_i),
    .reset_n_i          (reset_n_i),
    .redirect_v_i       (redirect_v_i),
    .redirect_br_i      (redirect_br_i),
    .redirect_bht_idx_i (redirect_bht_idx_i),
    .redirect_btb_w_i   (redirect_btb_w_i),
    .redirect_btb_clr_i (redirect_btb_clr_i),
    .redirect_btb_jmp_i (redirect_btb_jmp_i),
    .redirect_btb_idx_i (redirect_btb_idx_i),
    .redirect_btb_tag_i (redirect_btb_tag_i),
    .redirect_tgt_i     (redirect_tgt_i),
    .attaboy_v_i        (attaboy_v_i),
    .attaboy_bht_idx_i  (attaboy_bht_idx_i),
    .attaboy_yumi_o     (attaboy_yumi_o),
    .bht_w_v_o          (bht_w_v_o),
    .bht_w_idx_o        (bht_w_idx_o),
    .bht_w_clr_o        (bht_w_clr_o),
    .bht_w_correct_o    (bht_w_correct_o),
    .btb_w_v_o          (btb_w_v_o),
    .btb_w_clr_o        (btb_w_clr_o),
    .btb_w_jmp_o        (btb_w_jmp_o),
    .btb_w_idx_o        (btb_w_idx_o),
    .btb_w_tag_o        (btb_w_tag_o),
    .btb_w_tgt_o        (btb_w_tgt_o),
    .ready_o            (ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // BHT port view: {v, correct, clr, idx}
  function automatic logic [11:0] bht_view();
    return {bht_w_v_o, bht_w_correct_o, bht_w_clr_o, bht_w_idx_o};
  endfunction

  task automatic chk_quiet(input string tag);
    chk(tag, {ready_o, attaboy_yumi_o, bht_w_v_o, bht_w_clr_o, bht_w_correct_o, bht_w_idx_o,
              btb_w_v_o, btb_w_clr_o, btb_w_jmp_o, btb_w_idx_o, btb_w_tag_o}, 64'h0);
    chk({tag, "_tgt"}, btb_w_tgt_o, 64'h0);
  endtask

  task automatic idle_inputs();
    redirect_v_i       = 1'b0;
    redirect_br_i      = 1'b0;
    redirect_bht_idx_i = '0;
    redirect_btb_w_i   = 1'b0;
    redirect_btb_clr_i = 1'b0;
    redirect_btb_jmp_i = 1'b0;
    redirect_btb_idx_i = '0;
    redirect_btb_tag_i = '0;
    redirect_tgt_i     = '0;
    attaboy_v_i        = 1'b0;
    attaboy_bht_idx_i  = '0;
  endtask

  // Redirect and attaboy traffic that must be ignored before the tables are ready.
  task automatic noise_inputs();
    redirect_v_i       = 1'b1;
    redirect_br_i      = 1'b1;
    redirect_bht_idx_i = 9'h1FF;
    redirect_btb_w_i   = 1'b1;
    redirect_btb_clr_i = 1'b0;
    redirect_btb_jmp_i = 1'b1;
    redirect_btb_idx_i = 6'h3F;
    redirect_btb_tag_i = 10'h3FF;
    redirect_tgt_i     = 39'h7F_FFFF_FFFF;
    attaboy_v_i        = 1'b1;
    attaboy_bht_idx_i  = 9'h155;
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
    idle_inputs();
  endtask

  task automatic redirect_br(input logic [8:0] idx);
    redirect_v_i       = 1'b1;
    redirect_br_i      = 1'b1;
    redirect_bht_idx_i = idx;
  endtask

  task automatic attaboy(input logic [8:0] idx);
    attaboy_v_i       = 1'b1;
    attaboy_bht_idx_i = idx;
  endtask

  // Walks n clear cycles starting at cnt 0 (first edge must already have left idle).
  task automatic clear_walk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
      noise_inputs();
      #1;
      chk("clr_ctl", {ready_o, attaboy_yumi_o, bht_w_v_o, bht_w_clr_o, bht_w_correct_o,
                      bht_w_idx_o}, {2'b00, 1'b1, 1'b1, 1'b0, 9'(i)});
      if (i < 64) begin
        chk("clr_btb", {btb_w_v_o, btb_w_clr_o, btb_w_jmp_o, btb_w_idx_o, btb_w_tag_o},
            {1'b1, 1'b1, 1'b0, 6'(i), 10'h0});
        chk("clr_btb_tgt", btb_w_tgt_o, 64'h0);
      end else begin
        chk("clr_btb_off", {btb_w_v_o, btb_w_clr_o}, 2'b00);
      end
    end
  endtask

  initial begin
    reset_n_i = 1'b0;
    idle_inputs();

    // Reset held with traffic on the inputs: everything quiet.
    cyc();
    noise_inputs();
    #1;
    chk_quiet("rst_hold");

    // Released, still idle before the first edge.
    cyc();
    noise_inputs();
    reset_n_i = 1'b1;
    #1;
    chk_quiet("idle");

    clear_walk(512);

    // Edge 513: run mode, nothing pending.
    cyc();
    #1;
    chk("run_ready", {ready_o, bht_w_v_o, btb_w_v_o, attaboy_yumi_o}, 4'b1000);

    // Five back-to-back attaboys; each drains the cycle after it is accepted.
    for (int k = 0; k < 5; k++) begin
      cyc();
      attaboy(9'(k + 1));
      #1;
      chk("t2_yumi", attaboy_yumi_o, 1'b1);
      if (k == 0) chk("t2_bht_first", bht_w_v_o, 1'b0);
      else        chk("t2_bht", bht_view(), {3'b110, 9'(k)});
    end
    cyc();
    #1;
    chk("t2_bht_last", bht_view(), {3'b110, 9'd5});
    cyc();
    #1;
    chk("t2_bht_empty", bht_w_v_o, 1'b0);

    // Redirect pre-empts the queued head, which follows a cycle later.
    cyc();
    attaboy(9'd7);
    #1;
    chk("t3_yumi", attaboy_yumi_o, 1'b1);
    chk("t3_bht_idle", bht_w_v_o, 1'b0);
    cyc();
    redirect_br(9'h1A0);
    #1;
    chk("t3_redir", bht_view(), {3'b100, 9'h1A0});
    chk("t3_btb_off", btb_w_v_o, 1'b0);
    cyc();
    #1;
    chk("t3_head", bht_view(), {3'b110, 9'd7});
    cyc();
    #1;
    chk("t3_empty", bht_w_v_o, 1'b0);

    // BTB-only redirect: BHT port keeps serving the queue.
    cyc();
    attaboy(9'd9);
    #1;
    chk("t4_yumi", attaboy_yumi_o, 1'b1);
    cyc();
    redirect_v_i       = 1'b1;
    redirect_bht_idx_i = 9'h055;
    redirect_btb_w_i   = 1'b1;
    redirect_btb_jmp_i = 1'b1;
    redirect_btb_idx_i = 6'd3;
    redirect_btb_tag_i = 10'h2F;
    redirect_tgt_i     = 39'h00_8000_0040;
    #1;
    chk("t4_btb", {btb_w_v_o, btb_w_clr_o, btb_w_jmp_o, btb_w_idx_o, btb_w_tag_o},
        {1'b1, 1'b0, 1'b1, 6'd3, 10'h2F});
    chk("t4_tgt", btb_w_tgt_o, 64'h80000040);
    chk("t4_bht", bht_view(), {3'b110, 9'd9});
    // One redirect writing both tables in the same cycle.
    cyc();
    redirect_br(9'h0AB);
    redirect_btb_w_i   = 1'b1;
    redirect_btb_clr_i = 1'b1;
    redirect_btb_idx_i = 6'h3E;
    redirect_btb_tag_i = 10'h155;
    redirect_tgt_i     = 39'h12_3456_7800;
    #1;
    chk("t4b_btb", {btb_w_v_o, btb_w_clr_o, btb_w_jmp_o, btb_w_idx_o, btb_w_tag_o},
        {1'b1, 1'b1, 1'b0, 6'h3E, 10'h155});
    chk("t4b_tgt", btb_w_tgt_o, 64'h12_3456_7800);
    chk("t4b_bht", bht_view(), {3'b100, 9'h0AB});
    cyc();
    #1;
    chk("t4_quiet", {bht_w_v_o, btb_w_v_o}, 2'b00);

    // Redirects block the port while the queue fills.
    for (int k = 0; k < 4; k++) begin
      cyc();
      redirect_br(9'h100);
      attaboy(9'(9'h11 + k));
      #1;
      chk("t5_yumi_fill", attaboy_yumi_o, 1'b1);
      chk("t5_redir", bht_view(), {3'b100, 9'h100});
    end
    cyc();
    redirect_br(9'h100);
    attaboy(9'h15);
    #1;
    chk("t5_yumi_full", attaboy_yumi_o, 1'b0);
    chk("t5_redir_full", bht_view(), {3'b100, 9'h100});
    // Full with a dequeue this cycle: still refused.
    cyc();
    attaboy(9'h15);
    #1;
    chk("t5_yumi_deq", attaboy_yumi_o, 1'b0);
    chk("t5_head11", bht_view(), {3'b110, 9'h11});
    cyc();
    attaboy(9'h15);
    #1;
    chk("t5_yumi_free", attaboy_yumi_o, 1'b1);
    chk("t5_head12", bht_view(), {3'b110, 9'h12});
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      chk("t5_drain", bht_view(), {3'b110, 9'(9'h13 + k)});
    end
    cyc();
    #1;
    chk("t5_empty", bht_w_v_o, 1'b0);

    // Queue three attaboys, then reset mid-run.
    for (int k = 0; k < 3; k++) begin
      cyc();
      redirect_br(9'h100);
      attaboy(9'(9'h21 + k));
      #1;
      chk("t6_yumi", attaboy_yumi_o, 1'b1);
    end
    cyc();
    redirect_br(9'h100);
    attaboy(9'h24);
    reset_n_i = 1'b0;
    #1;
    chk_quiet("t6_rst_run");
    cyc();
    reset_n_i = 1'b1;
    #1;
    chk_quiet("t6_idle1");
    clear_walk(201);
    // Reset again at clear cnt 200.
    reset_n_i = 1'b0;
    #1;
    chk_quiet("t6_rst_clear");
    cyc();
    reset_n_i = 1'b1;
    #1;
    chk_quiet("t6_idle2");
    clear_walk(512);
    cyc();
    #1;
    chk("t6_ready", {ready_o, bht_w_v_o}, 2'b10);
    cyc();
    attaboy(9'h33);
    #1;
    chk("t6_no_stale", {attaboy_yumi_o, bht_w_v_o}, 2'b10);
    cyc();
    #1;
    chk("t6_fresh", bht_view(), {3'b110, 9'h33});
    cyc();
    #1;
    chk("t6_empty", bht_w_v_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
